// File: rtl/apb_mailbox_completer.sv
// APB completer exposing a TX FIFO (APB writes -> local consumer) and an RX FIFO
// (local producer -> APB reads), with STATUS/CTRL registers and a level interrupt.
module apb_mailbox_completer #(
  parameter int AWIDTH     = 4,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AWIDTH-1:0] apb_PADDR,
  input  logic              apb_PSEL,
  input  logic              apb_PENABLE,
  output logic              apb_PREADY,
  input  logic              apb_PWRITE,
  input  logic [31:0]       apb_PWDATA,
  output logic [31:0]       apb_PRDATA,
  output logic              apb_PSLVERROR,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic                  access, wr_access, rd_access;
  logic [1:0]            reg_sel;
  logic                  unused_addr;

  logic [31:0]           tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0]         tx_count;
  logic                  tx_full, tx_empty, tx_push, tx_pop, tx_flush;

  logic [31:0]           rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0]         rx_count;
  logic                  rx_full, rx_empty, rx_push, rx_pop, rx_flush;

  logic                  irq_en;
  logic [7:0]            tx_cnt8, rx_cnt8;
  logic [31:0]           rdata_nxt;
  logic                  err_nxt;

  // The edge that raises PREADY is the single commit point of every transfer.
  assign access      = apb_PSEL & apb_PENABLE & ~apb_PREADY;
  assign wr_access   = access & apb_PWRITE;
  assign rd_access   = access & ~apb_PWRITE;
  assign reg_sel     = apb_PADDR[3:2];
  assign unused_addr = ^apb_PADDR;

  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_push  = wr_access & (reg_sel == REG_DATA) & ~tx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_flush = wr_access & (reg_sel == REG_CTRL) & apb_PWDATA[0];
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_access & (reg_sel == REG_DATA) & ~rx_empty;
  assign rx_flush = wr_access & (reg_sel == REG_CTRL) & apb_PWDATA[1];

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rptr];
  assign rx_ready = ~rx_full;

  assign tx_cnt8 = 8'(tx_count);
  assign rx_cnt8 = 8'(rx_count);

  // Storage carries no reset; only pointers and counts define occupancy.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= apb_PWDATA;
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (tx_flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (rx_flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_comb begin
    rdata_nxt = '0;
    err_nxt   = 1'b0;
    unique case (reg_sel)
      REG_DATA: begin
        if (apb_PWRITE)    err_nxt = tx_full;
        else if (rx_empty) err_nxt = 1'b1;
        else               rdata_nxt = rx_mem[rx_rptr];
      end
      REG_STATUS: begin
        if (apb_PWRITE) err_nxt = 1'b1;
        else rdata_nxt = {8'h00, rx_cnt8, tx_cnt8, 4'h0,
                          rx_empty, rx_full, tx_empty, tx_full};
      end
      REG_CTRL: begin
        if (!apb_PWRITE) rdata_nxt = {29'b0, irq_en, 2'b00};
      end
      default: err_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      apb_PREADY    <= 1'b0;
      apb_PRDATA    <= '0;
      apb_PSLVERROR <= 1'b0;
      irq_en        <= 1'b0;
      irq           <= 1'b0;
    end else begin
      apb_PREADY <= access;
      if (access) begin
        apb_PRDATA    <= rdata_nxt;
        apb_PSLVERROR <= err_nxt;
      end
      if (wr_access && reg_sel == REG_CTRL) irq_en <= apb_PWDATA[2];
      irq <= irq_en & ~rx_empty;
    end
  end

endmodule

// File: tb/tb_apb_mailbox_completer.sv
// Self-checking bench for apb_mailbox_completer: table-driven APB transfers with a
// read/response scoreboard and a TX word scoreboard, plus hand-written corner sequences.
module tb_apb_mailbox_completer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  apb_PADDR;
  logic        apb_PSEL, apb_PENABLE, apb_PREADY, apb_PWRITE;
  logic [31:0] apb_PWDATA, apb_PRDATA;
  logic        apb_PSLVERROR;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  always #5 clk = ~clk;

  apb_mailbox_completer #(.AWIDTH(4), .DEPTH_LOG2(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .apb_PADDR(apb_PADDR), .apb_PSEL(apb_PSEL), .apb_PENABLE(apb_PENABLE),
    .apb_PREADY(apb_PREADY), .apb_PWRITE(apb_PWRITE), .apb_PWDATA(apb_PWDATA),
    .apb_PRDATA(apb_PRDATA), .apb_PSLVERROR(apb_PSLVERROR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t        vt[$];
  exp_t        rdq[$];
  logic [31:0] txq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = erd; v.exp_err = eerr;
    vt.push_back(v);
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
    apb_PSEL = 1'b1; apb_PENABLE = 1'b0; apb_PWRITE = wr; apb_PADDR = a; apb_PWDATA = wd;
    @(posedge clk); #1;
    apb_PENABLE = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!apb_PREADY && lat < 10);
    chk("pready_seen", {31'b0, apb_PREADY}, 32'd1);
    rd = apb_PRDATA;
    er = apb_PSLVERROR;
    apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
    @(posedge clk); #1;
    chk("pready_single_cycle", {31'b0, apb_PREADY}, 32'd0);
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_t        e;
      logic [31:0] rd;
      logic        er;
      int          lat;
      e.wr = vt[i].wr; e.rd = vt[i].exp_rd; e.err = vt[i].exp_err;
      rdq.push_back(e);
      if (vt[i].wr && vt[i].addr[3:2] == 2'd0 && !vt[i].exp_err) txq.push_back(vt[i].wdata);
      apb_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, lat);
      e = rdq.pop_front();
      chk($sformatf("vec%0d_latency", i), lat, 32'd1);
      chk($sformatf("vec%0d_pslverror", i), {31'b0, er}, {31'b0, e.err});
      if (!e.wr) chk($sformatf("vec%0d_prdata", i), rd, e.rd);
    end
  endtask

  task automatic drain_tx(input int n);
    for (int k = 0; k < n; k++) begin
      tx_ready = 1'b1;
      chk("tx_valid_during_drain", {31'b0, tx_valid}, 32'd1);
      if (txq.size() > 0) chk("tx_data_order", tx_data, txq.pop_front());
      else chk("tx_extra_word", {31'b0, tx_valid}, 32'd0);
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    chk("tx_empty_after_drain", {31'b0, tx_valid}, 32'd0);
  endtask

  task automatic rx_push(input logic [31:0] w);
    rx_valid = 1'b1; rx_data = w;
    chk("rx_ready_on_push", {31'b0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    // 0: reset STATUS; 1-3: TX writes + STATUS
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_000A, 1'b0);
    add_vec(1'b1, 4'h0, 32'h11, 32'h0, 1'b0);
    add_vec(1'b1, 4'h0, 32'h22, 32'h0, 1'b0);
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_0208, 1'b0);
    // 4: RX full STATUS; 5-12: RX reads; 13: underflow; 14: STATUS
    add_vec(1'b0, 4'h4, 32'h0, 32'h0008_0006, 1'b0);
    for (int i = 0; i < 8; i++) add_vec(1'b0, 4'h0, 32'h0, 32'hA0 + 32'(i), 1'b0);
    add_vec(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_000A, 1'b0);
    // 15-22: fill TX; 23: STATUS full; 24: STATUS after rejected write
    for (int i = 0; i < 8; i++) add_vec(1'b1, 4'h0, 32'h100 + 32'(i), 32'h0, 1'b0);
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_0809, 1'b0);
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_0708, 1'b0);
    // 25-26: irq_en; 27: flush rx; 28-33: error cases and readback
    add_vec(1'b1, 4'h8, 32'h4, 32'h0, 1'b0);
    add_vec(1'b0, 4'h8, 32'h0, 32'h4, 1'b0);
    add_vec(1'b1, 4'h8, 32'h6, 32'h0, 1'b0);
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_000A, 1'b0);
    add_vec(1'b1, 4'h4, 32'hFFFF, 32'h0, 1'b1);
    add_vec(1'b1, 4'hC, 32'h1234, 32'h0, 1'b1);
    add_vec(1'b0, 4'hC, 32'h0, 32'h0, 1'b1);
    add_vec(1'b0, 4'h8, 32'h0, 32'h4, 1'b0);
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_000A, 1'b0);
    // 34-35: post-reset STATUS and CTRL
    add_vec(1'b0, 4'h4, 32'h0, 32'h0000_000A, 1'b0);
    add_vec(1'b0, 4'h8, 32'h0, 32'h0, 1'b0);

    reset_n = 1'b0;
    apb_PSEL = 1'b0; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0; apb_PADDR = '0; apb_PWDATA = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    chk("reset_pready", {31'b0, apb_PREADY}, 32'd0);
    chk("reset_prdata", apb_PRDATA, 32'd0);
    chk("reset_pslverror", {31'b0, apb_PSLVERROR}, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("reset_rx_ready", {31'b0, rx_ready}, 32'd1);
    run_vec(0, 0);

    // TX path
    run_vec(1, 2);
    chk("tx_valid_after_writes", {31'b0, tx_valid}, 32'd1);
    chk("tx_head_fwft", tx_data, 32'h11);
    run_vec(3, 3);
    drain_tx(2);

    // RX path: fill, hold a 9th offer, read back
    for (int i = 0; i < 8; i++) rx_push(32'hA0 + 32'(i));
    rx_valid = 1'b1; rx_data = 32'hDEAD;
    chk("rx_ready_when_full", {31'b0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    run_vec(4, 14);

    // TX full with a same-edge consumer pop: write still rejected
    run_vec(15, 23);
    apb_PSEL = 1'b1; apb_PWRITE = 1'b1; apb_PADDR = 4'h0; apb_PWDATA = 32'hBAD; apb_PENABLE = 1'b0;
    @(posedge clk); #1;
    apb_PENABLE = 1'b1; tx_ready = 1'b1;
    chk("full_pop_head", tx_data, txq.pop_front());
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("full_write_pready", {31'b0, apb_PREADY}, 32'd1);
    chk("full_write_pslverror", {31'b0, apb_PSLVERROR}, 32'd1);
    apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
    @(posedge clk); #1;
    run_vec(24, 24);
    drain_tx(7);

    // Interrupt and flush
    run_vec(25, 26);
    rx_push(32'h55);
    chk("irq_not_yet", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_raised", {31'b0, irq}, 32'd1);
    run_vec(27, 27);
    chk("irq_after_flush", {31'b0, irq}, 32'd0);
    chk("rx_ready_after_flush", {31'b0, rx_ready}, 32'd1);
    run_vec(28, 33);

    // Reset right after the commit edge of a DATA write
    rx_push(32'h77);
    @(posedge clk); #1;
    chk("irq_before_reset", {31'b0, irq}, 32'd1);
    apb_PSEL = 1'b1; apb_PWRITE = 1'b1; apb_PADDR = 4'h0; apb_PWDATA = 32'h99; apb_PENABLE = 1'b0;
    @(posedge clk); #1;
    apb_PENABLE = 1'b1;
    @(posedge clk); #1;
    chk("prereset_pready", {31'b0, apb_PREADY}, 32'd1);
    chk("prereset_tx_valid", {31'b0, tx_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_pready", {31'b0, apb_PREADY}, 32'd0);
    chk("midreset_prdata", apb_PRDATA, 32'd0);
    chk("midreset_pslverror", {31'b0, apb_PSLVERROR}, 32'd0);
    chk("midreset_irq", {31'b0, irq}, 32'd0);
    chk("midreset_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("midreset_rx_ready", {31'b0, rx_ready}, 32'd1);
    apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    txq.delete();
    run_vec(34, 35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
